// File: rtl/dt_res_arbiter_if.sv
// dt_res_arbiter_if: requester-side and memory-side signals of the result
// memory arbiter. The arbiter takes the slave view. The master view is the
// environment: the requesters plus the memory that returns res_di.
interface dt_res_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 14,
    parameter int DW   = 8
);
    // requester side
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ-1:0]    lock;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               busy;
    // memory side
    logic               res_rd;
    logic               res_wr;
    logic [AW-1:0]      res_addr;
    logic [DW-1:0]      res_do;
    logic [DW-1:0]      res_di;

    modport master (
        output req, we, lock, addr, wdata, res_di,
        input  gnt, rvalid, rdata, busy, res_rd, res_wr, res_addr, res_do
    );

    modport slave (
        input  req, we, lock, addr, wdata, res_di,
        output gnt, rvalid, rdata, busy, res_rd, res_wr, res_addr, res_do
    );
endinterface

// File: rtl/dt_res_arbiter.sv
// dt_res_arbiter: round-robin arbiter with a bounded lock that shares one
// single-port result memory among NREQ requesters. The winner's command is
// registered onto the memory bus and its read data comes back as a one-hot
// rvalid two cycles after the grant.
module dt_res_arbiter #(
    parameter int NREQ     = 4,
    parameter int AW       = 14,
    parameter int DW       = 8,
    parameter int MAX_LOCK = 16
) (
    input logic             clk,
    input logic             reset,
    dt_res_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_LOCK + 1);

    // Arbitration state
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            own_vld_q, own_vld_d;
    logic [IW-1:0]   own_q, own_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Registered memory command
    logic            res_rd_q, res_wr_q;
    logic [AW-1:0]   res_addr_q;
    logic [DW-1:0]   res_do_q;

    // Read-return tag pipeline. Stage 1 matches the memory access cycle and
    // stage 2 matches the cycle when res_di is valid.
    logic            tag1_vld_q, tag2_vld_q;
    logic [IW-1:0]   tag1_q, tag2_q;

    // Current-cycle arbitration results
    logic            gnt_vld, lock_hit, lock_force;
    logic [IW-1:0]   win;
    logic            win_we, win_lock;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    logic [NREQ-1:0] gnt_oh, rvalid_oh;

    // Return the first requesting index at or after p, wrapping at NREQ.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   p);
        int s;
        logic found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            s = int'(p) + k;
            if (s >= NREQ) s = s - NREQ;
            if (!found && r[IW'(s)]) begin
                found   = 1'b1;
                rr_pick = IW'(s);
            end
        end
    endfunction

    // Pick the winner. A live lock owner wins until its grant budget is spent.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        lock_hit   = 1'b0;
        lock_force = 1'b0;
        gnt_vld    = |bus.req;
        win        = rr_pick(bus.req, ptr_q);
        if (own_vld_q && bus.req[own_q]) begin
            if (cnt_q < CW'(MAX_LOCK)) begin
                lock_hit = 1'b1;
                win      = own_q;
            end else begin
                lock_force = 1'b1;
            end
        end
        win_we    = bus.we[win];
        win_lock  = bus.lock[win];
        win_addr  = bus.addr[int'(win)*AW +: AW];
        win_wdata = bus.wdata[int'(win)*DW +: DW];
    end

    // Compute the next lock owner, lock count and round-robin pointer.
    always_comb begin
        ptr_d     = ptr_q;
        own_vld_d = own_vld_q;
        own_d     = own_q;
        cnt_d     = cnt_q;
        if (lock_force) begin
            // Budget spent: this arbitration ignored the lock, so drop it.
            own_vld_d = 1'b0;
            own_d     = '0;
            cnt_d     = '0;
        end else if (lock_hit) begin
            if (win_lock) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                own_vld_d = 1'b0;
                own_d     = '0;
                cnt_d     = '0;
            end
        end else if (gnt_vld && win_lock) begin
            own_vld_d = 1'b1;
            own_d     = win;
            cnt_d     = CW'(1);
        end else begin
            own_vld_d = 1'b0;
            own_d     = '0;
            cnt_d     = '0;
        end
        // The pointer stays put only while an existing lock keeps going.
        if (gnt_vld && !(lock_hit && win_lock)) begin
            ptr_d = (int'(win) == NREQ - 1) ? '0 : win + IW'(1);
        end
    end

    // Register arbitration state, the memory command and the read tags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            own_vld_q  <= 1'b0;
            own_q      <= '0;
            cnt_q      <= '0;
            res_rd_q   <= 1'b0;
            res_wr_q   <= 1'b0;
            res_addr_q <= '0;
            res_do_q   <= '0;
            tag1_vld_q <= 1'b0;
            tag1_q     <= '0;
            tag2_vld_q <= 1'b0;
            tag2_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values, which makes the tag pipeline shift correctly.
            ptr_q      <= ptr_d;
            own_vld_q  <= own_vld_d;
            own_q      <= own_d;
            cnt_q      <= cnt_d;
            res_rd_q   <= gnt_vld && !win_we;
            res_wr_q   <= gnt_vld && win_we;
            if (gnt_vld) begin
                res_addr_q <= win_addr;
                res_do_q   <= win_wdata;
            end
            tag1_vld_q <= gnt_vld && !win_we;
            tag1_q     <= win;
            tag2_vld_q <= tag1_vld_q;
            tag2_q     <= tag1_q;
        end
    end

    // Decode the one-hot grant and read-valid vectors.
    always_comb begin
        gnt_oh    = '0;
        rvalid_oh = '0;
        if (gnt_vld)    gnt_oh[win]       = 1'b1;
        if (tag2_vld_q) rvalid_oh[tag2_q] = 1'b1;
    end

    // The grant is combinational, so it is held low while reset is asserted.
    assign bus.gnt      = reset ? gnt_oh : '0;
    assign bus.rvalid   = rvalid_oh;
    assign bus.rdata    = bus.res_di;
    assign bus.busy     = tag1_vld_q | tag2_vld_q;
    assign bus.res_rd   = res_rd_q;
    assign bus.res_wr   = res_wr_q;
    assign bus.res_addr = res_addr_q;
    assign bus.res_do   = res_do_q;
endmodule

// File: tb/tb_dt_res_arbiter.sv
// tb_dt_res_arbiter: directed stimulus for the result memory arbiter. A
// transaction-level model (grant order, shadow memory, queue of pending reads)
// is checked against the DUT on every falling edge. The directed sequences
// also check hand-computed literal values.
`timescale 1ns/1ps
module tb_dt_res_arbiter;
    localparam int NREQ     = 4;
    localparam int AW       = 14;
    localparam int DW       = 8;
    localparam int MAX_LOCK = 16;
    localparam int DEPTH    = 1 << AW;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    dt_res_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    dt_res_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Initial memory contents, used by both the memory and the shadow model.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        case (a)
            14'h3FFF: return 8'd5;
            14'h0000: return 8'd7;
            14'h0001: return 8'd9;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Single-port memory: res_di is valid the cycle after res_rd.
    logic [DW-1:0] mem      [DEPTH];
    bit            mem_seen [DEPTH];
    always @(posedge clk) begin
        if (bus.res_rd)
            bus.res_di <= mem_seen[bus.res_addr] ? mem[bus.res_addr] : init_val(bus.res_addr);
        if (bus.res_wr) begin
            mem[bus.res_addr]      <= bus.res_do;
            mem_seen[bus.res_addr] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    rd_t           rq[$];
    logic [DW-1:0] shadow      [DEPTH];
    bit            shadow_seen [DEPTH];
    int            m_ptr = 0;
    int            m_own = -1;
    int            m_cnt = 0;
    logic          m_rd  = 1'b0;
    logic          m_wr  = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_do   = '0;

    int              w;
    bit              hit, frc, cont, busy_e;
    logic [NREQ-1:0] exp_rv;
    logic [DW-1:0]   exp_rdata;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            check("rst_gnt",    32'(bus.gnt), 0);
            check("rst_rvalid", 32'(bus.rvalid), 0);
            check("rst_res_rd", 32'(bus.res_rd), 0);
            check("rst_res_wr", 32'(bus.res_wr), 0);
            check("rst_addr",   32'(bus.res_addr), 0);
            check("rst_do",     32'(bus.res_do), 0);
            check("rst_busy",   32'(bus.busy), 0);
            rq.delete();
            m_ptr = 0; m_own = -1; m_cnt = 0;
            m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_do = '0;
        end else begin
            // Who should win this cycle
            w = -1; hit = 1'b0; frc = 1'b0;
            if (m_own >= 0 && bus.req[m_own]) begin
                if (m_cnt < MAX_LOCK) hit = 1'b1;
                else                  frc = 1'b1;
            end
            if (hit) w = m_own;
            else begin
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && bus.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            check("gnt", 32'(bus.gnt), (w >= 0) ? (32'd1 << w) : 32'd0);

            // Command issued by the previous grant
            check("res_rd",   32'(bus.res_rd), 32'(m_rd));
            check("res_wr",   32'(bus.res_wr), 32'(m_wr));
            check("res_addr", 32'(bus.res_addr), 32'(m_addr));
            check("res_do",   32'(bus.res_do), 32'(m_do));

            // Reads returning now, and reads still in flight
            exp_rv = '0; exp_rdata = '0; busy_e = 1'b0;
            foreach (rq[i]) begin
                if (rq[i].due == cyc) begin
                    exp_rv[rq[i].id] = 1'b1;
                    exp_rdata        = rq[i].data;
                end
                if (rq[i].due == cyc || rq[i].due == cyc + 1) busy_e = 1'b1;
            end
            check("rvalid", 32'(bus.rvalid), 32'(exp_rv));
            check("busy",   32'(bus.busy), 32'(busy_e));
            if (exp_rv != '0) check("rdata", 32'(bus.rdata), 32'(exp_rdata));
            while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());

            // Apply this cycle's grant in grant order
            if (w >= 0) begin
                a = bus.addr[w*AW +: AW];
                d = bus.wdata[w*DW +: DW];
                if (bus.we[w]) begin
                    shadow[a] = d; shadow_seen[a] = 1'b1;
                    m_rd = 1'b0; m_wr = 1'b1;
                end else begin
                    rq.push_back('{id: w, data: (shadow_seen[a] ? shadow[a] : init_val(a)), due: cyc + 2});
                    m_rd = 1'b1; m_wr = 1'b0;
                end
                m_addr = a; m_do = d;
            end else begin
                m_rd = 1'b0; m_wr = 1'b0;
            end

            // Lock bookkeeping and pointer
            cont = hit && bus.lock[w];
            if (frc) begin
                m_own = -1; m_cnt = 0;
            end else if (hit) begin
                if (bus.lock[w]) m_cnt++;
                else begin m_own = -1; m_cnt = 0; end
            end else if (w >= 0 && bus.lock[w]) begin
                m_own = w; m_cnt = 1;
            end else begin
                m_own = -1; m_cnt = 0;
            end
            if (w >= 0 && !cont) m_ptr = (w + 1) % NREQ;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus.req  = '0;
        bus.we   = '0;
        bus.lock = '0;
    endtask

    task automatic put(input int i, input bit wr, input bit lk,
                       input logic [AW-1:0] ad, input logic [DW-1:0] dat);
        bus.req[i]            = 1'b1;
        bus.we[i]             = wr;
        bus.lock[i]           = lk;
        bus.addr[i*AW +: AW]  = ad;
        bus.wdata[i*DW +: DW] = dat;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    logic [NREQ-1:0] exp_g;

    initial begin
        bus.req = '0; bus.we = '0; bus.lock = '0; bus.addr = '0; bus.wdata = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;

        // Reset in the middle of a read
        next_cycle(); put(1, 0, 0, 14'h0100, 8'h00); settle();
        check("t1_gnt", 32'(bus.gnt), 32'h2);
        next_cycle(); put(1, 0, 0, 14'h0100, 8'h00);
        check("t1_res_rd_pre",   32'(bus.res_rd), 1);
        check("t1_res_addr_pre", 32'(bus.res_addr), 32'h0100);
        #2 reset = 1'b0;
        #1;
        check("t1_res_rd",   32'(bus.res_rd), 0);
        check("t1_res_addr", 32'(bus.res_addr), 0);
        check("t1_gnt_rst",  32'(bus.gnt), 0);
        check("t1_busy",     32'(bus.busy), 0);
        settle();
        bus.req = '0;
        #2 reset = 1'b1;
        repeat (3) begin
            next_cycle(); settle();
            check("t1_rvalid", 32'(bus.rvalid), 0);
        end

        // Single requester, back-to-back reads
        next_cycle(); put(2, 0, 0, 14'h3FFF, 8'h00); settle();
        check("t2_gnt0", 32'(bus.gnt), 32'h4);
        next_cycle(); put(2, 0, 0, 14'h0000, 8'h00); settle();
        check("t2_gnt1", 32'(bus.gnt), 32'h4);
        next_cycle(); put(2, 0, 0, 14'h0001, 8'h00); settle();
        check("t2_gnt2",   32'(bus.gnt), 32'h4);
        check("t2_rv0",    32'(bus.rvalid), 32'h4);
        check("t2_rdata0", 32'(bus.rdata), 5);
        next_cycle(); settle();
        check("t2_rv1",    32'(bus.rvalid), 32'h4);
        check("t2_rdata1", 32'(bus.rdata), 7);
        next_cycle(); settle();
        check("t2_rv2",    32'(bus.rvalid), 32'h4);
        check("t2_rdata2", 32'(bus.rdata), 9);
        next_cycle(); settle();
        check("t2_rv3",    32'(bus.rvalid), 0);

        // Bring ptr back to 0, then fairness with everyone requesting
        next_cycle(); put(3, 0, 0, 14'h0010, 8'h00); settle();
        check("t3_pre", 32'(bus.gnt), 32'h8);
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            for (int i = 0; i < NREQ; i++) put(i, 0, 0, AW'(i*256 + c), 8'h00);
            settle();
            exp_g = NREQ'(1) << (c % NREQ);
            check("t3_rr", 32'(bus.gnt), 32'(exp_g));
        end
        repeat (2) begin next_cycle(); settle(); end

        // Write followed by a read of the same address
        next_cycle(); put(0, 1, 0, 14'h0042, 8'hA5); settle();
        check("t4_gnt_w", 32'(bus.gnt), 32'h1);
        next_cycle(); put(1, 0, 0, 14'h0042, 8'h00); settle();
        check("t4_gnt_r",  32'(bus.gnt), 32'h2);
        check("t4_res_wr", 32'(bus.res_wr), 1);
        check("t4_addr",   32'(bus.res_addr), 32'h0042);
        check("t4_do",     32'(bus.res_do), 32'hA5);
        next_cycle(); settle();
        next_cycle(); settle();
        check("t4_rv",    32'(bus.rvalid), 32'h2);
        check("t4_rdata", 32'(bus.rdata), 32'hA5);

        // Lock budget: requester 3 holds for MAX_LOCK grants, then rotation
        next_cycle(); put(2, 0, 0, 14'h0200, 8'h00); settle();
        check("t5_pre", 32'(bus.gnt), 32'h4);
        for (int c = 0; c < MAX_LOCK + 4; c++) begin
            next_cycle();
            for (int i = 0; i < 3; i++) put(i, 0, 0, AW'(16*i + c), 8'h00);
            put(3, 0, 1, AW'(14'h1000 + c), 8'h00);
            settle();
            exp_g = (c < MAX_LOCK) ? NREQ'(8) : NREQ'(1) << (c - MAX_LOCK);
            check("t5_lock", 32'(bus.gnt), 32'(exp_g));
        end
        next_cycle(); settle();

        // Lock release: requester 1 locks, drops lock on its third grant
        next_cycle(); put(0, 0, 0, 14'h0300, 8'h00); settle();
        check("t6_pre", 32'(bus.gnt), 32'h1);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            put(0, 0, 0, AW'(14'h0400 + c), 8'h00);
            put(2, 0, 0, AW'(14'h0500 + c), 8'h00);
            put(1, 0, (c < 2), AW'(14'h0600 + c), 8'h00);
            settle();
            check("t6_rel", 32'(bus.gnt), (c < 3) ? 32'h2 : 32'h4);
        end
        repeat (3) begin next_cycle(); settle(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
